// File: rtl/psum_deskew.sv
// psum_deskew -- output-side deskew buffer for the systolic array.
//
// Partial sums leave the array as a 45-degree wavefront: column j of a row
// arrives j cycles after column 0. Each column is delayed by
// SYSTOLIC_SIZE-1-j registers so that a whole row appears in one cycle with a
// single valid strobe. A job frames frame_len rows. In test mode the array is
// driven in parallel, so data and valid bypass the alignment with zero latency.
//
// Optional feature macro: PSUM_DESKEW_SIGNATURE_EN
//   defined   -> running rotate/XOR signature over every emitted row
//   undefined -> signature tied to zero
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle job start, accepted only in IDLE
//   frame_len       rows in the job, sampled with start
//   test_mode       1 = parallel input (bypass), sampled with start
//   psum_valid_in   column-0 element of a new row is present
//   psum_in_flat    skewed input, column k at [k*PSUM_WIDTH +: PSUM_WIDTH]
//   psum_out_flat   aligned row, same packing
//   psum_valid_out  aligned row valid
//   out_row_idx     index of the row on psum_out_flat
//   busy            high while the job runs
//   done            one-cycle pulse at job completion
//   err             sticky overrun flag, cleared by the next accepted start
//   signature       output-row signature (zero unless the macro is defined)
module psum_deskew #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int PSUM_WIDTH    = 24
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [7:0]                          frame_len,
  input  logic                                test_mode,
  input  logic                                psum_valid_in,
  input  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] psum_in_flat,
  output logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] psum_out_flat,
  output logic                                psum_valid_out,
  output logic [7:0]                          out_row_idx,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [PSUM_WIDTH-1:0]               signature
);

  localparam int FW = SYSTOLIC_SIZE * PSUM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    frame_len_r;
  logic [7:0]    in_cnt_r;
  logic          mode_r;
  logic          start_ok_s;
  logic          in_full_s;
  logic          gated_valid_s;
  logic          last_row_s;
  logic          valid_dly_s;
  logic [FW-1:0] skew_out_s;

  assign start_ok_s    = start && (state_r == S_IDLE);
  assign in_full_s     = (in_cnt_r == frame_len_r);
  // Rows beyond frame_len are dropped here so they never reach the output.
  assign gated_valid_s = psum_valid_in && (state_r == S_RUN) && !in_full_s;
  assign last_row_s    = psum_valid_out && (state_r == S_RUN) &&
                         (out_row_idx == (frame_len_r - 8'd1));
  assign busy          = (state_r == S_RUN);
  assign done          = (state_r == S_DONE);

  // Per-column delay lines; the last column needs no delay.
  for (genvar j = 0; j < SYSTOLIC_SIZE; j++) begin : g_col
    if (j == SYSTOLIC_SIZE - 1) begin : g_pass
      assign skew_out_s[j*PSUM_WIDTH +: PSUM_WIDTH] = psum_in_flat[j*PSUM_WIDTH +: PSUM_WIDTH];
    end else begin : g_dly
      localparam int D = SYSTOLIC_SIZE - 1 - j;
      logic [PSUM_WIDTH-1:0] dly_r [D];

      // Free-running shift of column j; cleared by reset so no stale row leaks out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) dly_r[k] <= {PSUM_WIDTH{1'b0}};
        end else begin
          dly_r[0] <= psum_in_flat[j*PSUM_WIDTH +: PSUM_WIDTH];
          for (int k = 1; k < D; k++) dly_r[k] <= dly_r[k-1];
        end
      end

      assign skew_out_s[j*PSUM_WIDTH +: PSUM_WIDTH] = dly_r[D-1];
    end
  end

  // Valid strobe follows column 0 through the same depth as the longest delay line.
  if (SYSTOLIC_SIZE > 1) begin : g_vpipe
    logic [SYSTOLIC_SIZE-2:0] vpipe_r;

    // Valid shift register, one stage per alignment cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe_r <= {(SYSTOLIC_SIZE-1){1'b0}};
      end else begin
        vpipe_r[0] <= gated_valid_s;
        for (int k = 1; k < SYSTOLIC_SIZE - 1; k++) vpipe_r[k] <= vpipe_r[k-1];
      end
    end

    assign valid_dly_s = vpipe_r[SYSTOLIC_SIZE-2];
  end else begin : g_vpass
    assign valid_dly_s = gated_valid_s;
  end

  // Output select: aligned path or zero-latency bypass. The pass-through
  // columns are forced to zero during reset so the output reads all-zero.
  always_comb begin
    psum_out_flat  = {FW{1'b0}};
    psum_valid_out = 1'b0;
    if (!rst_n) begin
      psum_out_flat  = {FW{1'b0}};
      psum_valid_out = 1'b0;
    end else if (mode_r) begin
      psum_out_flat  = psum_in_flat;
      psum_valid_out = gated_valid_s;
    end else begin
      psum_out_flat  = skew_out_s;
      psum_valid_out = valid_dly_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = (frame_len == 8'd0) ? S_DONE : S_RUN;
        else       state_s = S_IDLE;
      end
      S_RUN: begin
        if (last_row_s) state_s = S_DONE;
        else            state_s = S_RUN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Job configuration, row counters and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_len_r <= 8'd0;
      mode_r      <= 1'b0;
      in_cnt_r    <= 8'd0;
      out_row_idx <= 8'd0;
      err         <= 1'b0;
    end else if (start_ok_s) begin
      frame_len_r <= frame_len;
      mode_r      <= test_mode;
      in_cnt_r    <= 8'd0;
      out_row_idx <= 8'd0;
      err         <= 1'b0;
    end else begin
      if (gated_valid_s) in_cnt_r <= in_cnt_r + 8'd1;
      if ((state_r == S_RUN) && psum_valid_in && in_full_s) err <= 1'b1;
      if ((state_r == S_RUN) && psum_valid_out) out_row_idx <= out_row_idx + 8'd1;
    end
  end

`ifdef PSUM_DESKEW_SIGNATURE_EN
  // XOR of all columns of one row.
  function automatic logic [PSUM_WIDTH-1:0] fold_cols(input logic [FW-1:0] row);
    logic [PSUM_WIDTH-1:0] acc;
    acc = {PSUM_WIDTH{1'b0}};
    for (int k = 0; k < SYSTOLIC_SIZE; k++) acc = acc ^ row[k*PSUM_WIDTH +: PSUM_WIDTH];
    return acc;
  endfunction

  logic [PSUM_WIDTH-1:0] sig_r;

  // Rotate-left-and-fold signature; holds after done for self-test readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= {PSUM_WIDTH{1'b0}};
    end else if (start_ok_s) begin
      sig_r <= {PSUM_WIDTH{1'b0}};
    end else if (psum_valid_out) begin
      sig_r <= {sig_r[PSUM_WIDTH-2:0], sig_r[PSUM_WIDTH-1]} ^ fold_cols(psum_out_flat);
    end
  end

  assign signature = sig_r;
`else
  assign signature = {PSUM_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_psum_deskew.sv
// Self-checking bench for psum_deskew (SYSTOLIC_SIZE = 4, PSUM_WIDTH = 16).
// Each job is planned as a table of per-cycle inputs; the expected outputs are
// derived from the job plan (row r accepted at cycle a appears at a+latency).
`timescale 1ns/1ps
module tb_psum_deskew;
  localparam int N    = 4;
  localparam int W    = 16;
  localparam int FW   = N * W;
  localparam int MAXC = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    frame_len;
  logic          test_mode;
  logic          psum_valid_in;
  logic [FW-1:0] psum_in_flat;
  logic [FW-1:0] psum_out_flat;
  logic          psum_valid_out;
  logic [7:0]    out_row_idx;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  signature;

  always #5 clk = ~clk;

  psum_deskew #(.SYSTOLIC_SIZE(N), .PSUM_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .test_mode(test_mode), .psum_valid_in(psum_valid_in),
    .psum_in_flat(psum_in_flat), .psum_out_flat(psum_out_flat),
    .psum_valid_out(psum_valid_out), .out_row_idx(out_row_idx),
    .busy(busy), .done(done), .err(err), .signature(signature)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic         m_err;
  logic [W-1:0] m_sig;
  logic [W-1:0] row_data [8][N];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Signature rule: rotate left by one, then XOR in every column of the row.
  function automatic logic [W-1:0] sig_step(input logic [W-1:0] s, input logic [FW-1:0] row);
    int x;
    x = ((int'(s) * 2) % 65536) + (int'(s) / 32768);
    for (int j = 0; j < N; j++) x = x ^ int'(row[j*W +: W]);
    return x[W-1:0];
  endfunction

  task automatic fill_rows_random();
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < N; j++) row_data[r][j] = W'($urandom);
  endtask

  // Plan and run one job. rst_at >= 0 aborts the job with an async reset in that cycle.
  task automatic run_job(input bit mode, input int fl, input bit rgap, input int n_extra,
                         input bit ov_first, input bit sstart, input int rst_at);
    bit            vin  [MAXC];
    bit            st   [MAXC];
    bit            accb [MAXC];
    bit            ev   [MAXC];
    int            eidx [MAXC];
    logic [W-1:0]  col  [MAXC][N];
    logic [FW-1:0] erow [MAXC];
    int            acc  [8];
    int            c, lat, olast, d, lo, p, outs;

    lat = mode ? 0 : N - 1;
    for (int i = 0; i < MAXC; i++) begin
      vin[i] = 1'b0; st[i] = 1'b0; accb[i] = 1'b0; ev[i] = 1'b0; eidx[i] = 0;
      erow[i] = {FW{1'b0}};
      for (int j = 0; j < N; j++) col[i][j] = W'($urandom);
    end
    vin[0] = 1'($urandom_range(0, 1));   // stray valid in IDLE, must be ignored
    st[0]  = 1'b1;
    c = 1 + (rgap ? int'($urandom_range(0, 2)) : 0);
    for (int k = 0; k < fl; k++) begin
      acc[k] = c; vin[c] = 1'b1; accb[c] = 1'b1;
      for (int j = 0; j < N; j++) begin
        col[c + (mode ? 0 : j)][j] = row_data[k][j];
        erow[c + lat][j*W +: W]    = row_data[k][j];
      end
      ev[c + lat] = 1'b1; eidx[c + lat] = k;
      c = c + 1 + (rgap ? int'($urandom_range(0, 2)) : 0);
    end
    olast = (fl > 0) ? acc[fl-1] + lat : 0;
    d     = (fl > 0) ? olast + 1 : 1;
    lo    = (fl > 0) ? acc[fl-1] + 1 : 0;
    for (int e = 0; e < n_extra; e++) begin
      p = (e == 0 && ov_first && fl > 0) ? lo : int'($urandom_range(lo, d + 1));
      vin[p] = 1'b1;
    end
    if (sstart)
      for (int i = 1; i <= d; i++) st[i] = 1'($urandom_range(0, 1));

    outs = 0;
    for (int cy = 0; cy <= d + 1; cy++) begin
      @(negedge clk);
      start         = st[cy];
      frame_len     = (cy == 0) ? 8'(fl) : 8'($urandom);
      test_mode     = (cy == 0) ? mode : 1'($urandom);
      psum_valid_in = vin[cy];
      for (int j = 0; j < N; j++) psum_in_flat[j*W +: W] = col[cy][j];
      #1;
      chk_eq("valid_out", psum_valid_out, ev[cy]);
      if (psum_valid_out) outs++;
      if (ev[cy]) begin
        chk_eq("row_data", psum_out_flat, erow[cy]);
        chk_eq("row_idx", out_row_idx, eidx[cy]);
      end
      chk_eq("busy", busy, (fl > 0 && cy >= 1 && cy <= olast));
      chk_eq("done", done, (cy == d));
      chk_eq("err", err, m_err);
      chk_eq("signature", signature, m_sig);
      if (cy == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_valid", psum_valid_out, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_err", err, 1'b0);
        chk_eq("rst_done", done, 1'b0);
        chk_eq("rst_idx", out_row_idx, 8'd0);
        chk_eq("rst_data", psum_out_flat, 64'd0);
        chk_eq("rst_sig", signature, 16'd0);
        m_err = 1'b0; m_sig = {W{1'b0}};
        @(negedge clk);
        start = 1'b0; psum_valid_in = 1'b0; rst_n = 1'b1;
        return;
      end
      if (cy == 0) begin m_err = 1'b0; m_sig = {W{1'b0}}; end
      if (fl > 0 && vin[cy] && !accb[cy] && cy >= 1 && cy <= olast) m_err = 1'b1;
`ifdef PSUM_DESKEW_SIGNATURE_EN
      if (ev[cy]) m_sig = sig_step(m_sig, erow[cy]);
`endif
    end
    chk_eq("row_count", outs, fl);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_len = 8'd0; test_mode = 1'b0;
    psum_valid_in = 1'b0; psum_in_flat = {FW{1'b0}};
    m_err = 1'b0; m_sig = {W{1'b0}};

    // Reset held with random inputs: every output stays at zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom); frame_len = 8'($urandom); test_mode = 1'($urandom);
      psum_valid_in = 1'($urandom);
      for (int j = 0; j < N; j++) psum_in_flat[j*W +: W] = W'($urandom);
      #1;
      chk_eq("reset_valid", psum_valid_out, 1'b0);
      chk_eq("reset_data", psum_out_flat, 64'd0);
      chk_eq("reset_idx", out_row_idx, 8'd0);
      chk_eq("reset_busy", busy, 1'b0);
      chk_eq("reset_done", done, 1'b0);
      chk_eq("reset_err", err, 1'b0);
      chk_eq("reset_sig", signature, 16'd0);
    end
    @(negedge clk);
    start = 1'b0; psum_valid_in = 1'b0; test_mode = 1'b0; rst_n = 1'b1;

    // Normal deskew: row r column j = 0x10*r + j, back-to-back rows.
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < N; j++) row_data[r][j] = W'(16 * r + j);
    run_job(1'b0, 2, 1'b0, 0, 1'b0, 1'b0, -1);

    // Bypass: one row {D,C,B,A} passes with zero latency.
    for (int j = 0; j < N; j++) row_data[0][j] = W'(10 + j);
    run_job(1'b1, 1, 1'b0, 0, 1'b0, 1'b0, -1);

    // Zero-length job, then a job with starts issued while it runs.
    run_job(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, -1);
    fill_rows_random();
    run_job(1'b0, 3, 1'b1, 0, 1'b0, 1'b1, -1);

    // Overrun: two row strobes for a one-row job; err stays set until next start.
    fill_rows_random();
    run_job(1'b0, 1, 1'b0, 1, 1'b1, 1'b0, -1);
    chk_eq("overrun_err_held", err, 1'b1);

    // Signature rows {1,2,3,4} then {0,0,0,0}.
    for (int j = 0; j < N; j++) begin
      row_data[0][j] = W'(j + 1);
      row_data[1][j] = {W{1'b0}};
    end
    run_job(1'b0, 2, 1'b0, 0, 1'b0, 1'b0, -1);
`ifdef PSUM_DESKEW_SIGNATURE_EN
    chk_eq("signature_final", signature, 16'h0008);
`else
    chk_eq("signature_final", signature, 16'h0000);
`endif

    // Randomized jobs.
    for (int n = 0; n < 25; n++) begin
      fill_rows_random();
      run_job(1'($urandom), int'($urandom_range(0, 6)), 1'b1, int'($urandom_range(0, 2)),
              1'($urandom), 1'($urandom), -1);
    end

    // Reset asserted mid-job while a row is on the output and err is set.
    fill_rows_random();
    run_job(1'b0, 1, 1'b0, 1, 1'b1, 1'b0, 4);

    // The block recovers into a clean job after the mid-job reset.
    fill_rows_random();
    run_job(1'b0, 4, 1'b1, 1, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_deskew.md
# psum_deskew

Output-side deskew buffer for the systolic array. Partial sums leave the bottom of the array as a 45-degree wavefront: column j of output row r arrives j cycles after column 0. This block re-aligns each row so that all SYSTOLIC_SIZE columns appear in the same cycle with one valid strobe, and frames a fixed number of rows per job. In test mode the array is driven in parallel, so alignment is bypassed.

## Interface
- SYSTOLIC_SIZE, 8, number of array columns; integer ≥ 1.
- PSUM_WIDTH, 24, width of one partial sum.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle job start; accepted only in IDLE.
- frame_len  input  8  rows in the job; sampled with start.
- test_mode  input  1  0 = skewed input (deskew active), 1 = parallel input (bypass); sampled with start.
- psum_valid_in  input  1  column-0 element of a new row is present this cycle.
- psum_in_flat  input  SYSTOLIC_SIZE*PSUM_WIDTH  column k at bits [k*PSUM_WIDTH +: PSUM_WIDTH].
- psum_out_flat  output  SYSTOLIC_SIZE*PSUM_WIDTH  aligned row, same packing.
- psum_valid_out  output  1  aligned row valid.
- out_row_idx  output  8  index of the row currently on psum_out_flat.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the job completes.
- err  output  1  sticky overrun flag.
- signature  output  PSUM_WIDTH  output-row signature; see Configuration.

## Operation
- Delay line: column j passes through D(j) = SYSTOLIC_SIZE-1-j registers in normal mode. Column SYSTOLIC_SIZE-1 is a combinational pass-through, and so is the whole datapath when SYSTOLIC_SIZE = 1. Delay registers shift every cycle and have no enable.
- Valid pipe: gated_valid = psum_valid_in & (state == RUN) & ~in_full. It feeds a SYSTOLIC_SIZE-1 stage shift register, and psum_valid_out is the last stage.
- Bypass: when mode_q = 1, psum_out_flat = psum_in_flat and psum_valid_out = gated_valid with zero delay. mode_q is test_mode latched at start and held until the next start.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start, latch frame_len and mode_q, clear in_cnt, out_row_idx and err. Go to DONE if frame_len = 0, otherwise go to RUN.
  - RUN: each gated_valid increments in_cnt, and in_full = (in_cnt == frame_len). Each psum_valid_out increments out_row_idx. When psum_valid_out is high and out_row_idx == frame_len-1, go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- Overrun: psum_valid_in while in RUN with in_full = 1 is dropped and sets err. err holds until the next accepted start.
- psum_valid_in in IDLE or DONE is ignored and does not set err.
- start while in RUN or DONE is ignored.
- Arithmetic: no computation on data; counters are 8-bit and cannot wrap because they are bounded by frame_len ≤ 255.

## Timing
- Reset values: psum_out_flat = 0, all delay registers = 0, psum_valid_out = 0, out_row_idx = 0, busy = 0, done = 0, err = 0, signature = 0, state = IDLE, mode_q = 0.
- Normal-mode latency: column j of row r sampled at cycle t0+r+j appears on psum_out_flat at cycle t0+r+SYSTOLIC_SIZE-1 for every j.
- psum_valid_out rises SYSTOLIC_SIZE-1 cycles after the accepted psum_valid_in.
- Bypass latency is 0.
- busy rises the cycle after start.
- done is asserted the cycle after the last psum_valid_out; busy is low in that same cycle.
- No backpressure: the array cannot stall, so every accepted row is emitted.
- Reset mid-job: all outputs return to their reset values immediately; delay registers are cleared, so no partial row is ever emitted.

## Configuration
- Macro: PSUM_DESKEW_SIGNATURE_EN.
- With the macro defined: signature is cleared on start. On each psum_valid_out, signature <= {signature[PSUM_WIDTH-2:0], signature[PSUM_WIDTH-1]} ^ (XOR of all columns of psum_out_flat). The value holds after done, for self-test comparison.
- Without the macro: no signature logic is compiled and signature is tied to 0.

## Test plan
All scenarios use SYSTOLIC_SIZE = 4 and PSUM_WIDTH = 16.
- Reset: hold rst_n low for 3 cycles with random inputs → all outputs 0 and state IDLE; assert rst_n mid-RUN → psum_valid_out, busy and err drop to 0 asynchronously.
- Normal deskew: start, frame_len = 2, test_mode = 0. Feed column j of row r = 0x10*r + j at cycle t0+r+j → psum_valid_out at t0+3 with {3,2,1,0}, at t0+4 with {0x13,0x12,0x11,0x10}, out_row_idx 0 then 1, done at t0+5.
- Bypass: test_mode = 1, frame_len = 1, psum_in_flat = {0xD,0xC,0xB,0xA} with psum_valid_in in the same cycle → identical data and psum_valid_out in that cycle; done one cycle later.
- Zero length and ignored start: frame_len = 0 → done the cycle after start and no psum_valid_out; a second start during RUN is ignored.
- Overrun: frame_len = 1 with 2 psum_valid_in pulses → exactly 1 output row, err = 1 until the next start.
- Signature (macro defined): rows {1,2,3,4} then {0,0,0,0} → signature 0x0004 after row 0 and 0x0008 after row 1; without the macro it stays 0.
